// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer for the IQ ROM NCO: steps freq from
// f_start towards f_stop with a programmable dwell, for a set number of sweeps.
module nco_sweep_ctrl #(
    parameter int FW = 28,
    parameter int DW = 16,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [RW-1:0] repeats,
    input  logic          sync_phase,
    output logic [FW-1:0] freq,
    output logic          accum_rst,
    output logic          busy,
    output logic          sweep_start,
    output logic          done,
    output logic          err,
    output logic [0:0]    dbg_state
);

    // start and abort are single-cycle requests with no ready: start is taken
    // only in IDLE with abort low, abort wins over everything in any state.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [FW-1:0] r_f_start;
    logic [FW-1:0] r_f_stop;
    logic [FW-1:0] r_f_step;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] r_dwell_cnt;
    logic [RW-1:0] r_sweeps;
    logic          r_sync;
    logic [FW-1:0] r_freq;
    logic          r_accum_rst;
    logic          r_busy;
    logic          r_sweep_start;
    logic          r_done;
    logic          r_err;

    logic [FW:0]   w_next;
    logic          w_dwell_end;
    logic          w_can_step;
    logic          w_last_sweep;
    logic          w_start_ok;
    logic          w_bad_cfg;
    logic [DW-1:0] w_dwell_in;

    // The sum keeps its carry so a wrapped step always ends the sweep.
    assign w_next       = {1'b0, r_freq} + {1'b0, r_f_step};
    assign w_dwell_end  = (r_dwell_cnt == r_dwell - DW'(1));
    assign w_can_step   = (r_f_step != '0) && (w_next <= {1'b0, r_f_stop});
    assign w_last_sweep = (r_sweeps == RW'(1));
    assign w_start_ok   = start && !abort;
    assign w_bad_cfg    = (f_start > f_stop);
    assign w_dwell_in   = (dwell == '0) ? DW'(1) : dwell;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_f_start     <= '0;
            r_f_stop      <= '0;
            r_f_step      <= '0;
            r_dwell       <= DW'(1);
            r_dwell_cnt   <= '0;
            r_sweeps      <= '0;
            r_sync        <= 1'b0;
            r_freq        <= '0;
            r_accum_rst   <= 1'b0;
            r_busy        <= 1'b0;
            r_sweep_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_accum_rst   <= 1'b0;
            r_sweep_start <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_freq      <= '0;
                r_busy      <= 1'b0;
                r_dwell_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_freq      <= '0;
                        r_busy      <= 1'b0;
                        r_dwell_cnt <= '0;
                        if (w_start_ok) begin
                            r_f_start <= f_start;
                            r_f_stop  <= f_stop;
                            r_f_step  <= f_step;
                            r_dwell   <= w_dwell_in;
                            r_sweeps  <= repeats;
                            r_sync    <= sync_phase;
                            if (w_bad_cfg) begin
                                r_err <= 1'b1;
                            end else begin
                                r_state       <= S_RUN;
                                r_freq        <= f_start;
                                r_busy        <= 1'b1;
                                r_sweep_start <= 1'b1;
                                r_accum_rst   <= sync_phase;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!w_dwell_end) begin
                            r_dwell_cnt <= r_dwell_cnt + DW'(1);
                        end else begin
                            r_dwell_cnt <= '0;
                            if (w_can_step) begin
                                r_freq <= w_next[FW-1:0];
                            end else if (!w_last_sweep) begin
                                // A zero sweep count never reaches 1, so it runs until abort.
                                if (r_sweeps != '0) begin
                                    r_sweeps <= r_sweeps - RW'(1);
                                end
                                r_freq        <= r_f_start;
                                r_sweep_start <= 1'b1;
                                r_accum_rst   <= r_sync;
                            end else begin
                                r_state <= S_IDLE;
                                r_freq  <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_freq  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign freq        = r_freq;
    assign accum_rst   = r_accum_rst;
    assign busy        = r_busy;
    assign sweep_start = r_sweep_start;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: expected per-cycle output vectors are
// built from the sweep timing rules and compared cycle by cycle.
module tb_nco_sweep_ctrl;

    localparam int FW = 28;
    localparam int DW = 16;
    localparam int RW = 8;
    localparam int W  = FW + 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic [RW-1:0] repeats;
    logic          sync_phase;
    logic [FW-1:0] freq;
    logic          accum_rst;
    logic          busy;
    logic          sweep_start;
    logic          done;
    logic          err;
    logic [0:0]    dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.FW(FW), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .repeats(repeats), .sync_phase(sync_phase),
        .freq(freq), .accum_rst(accum_rst), .busy(busy),
        .sweep_start(sweep_start), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    function automatic logic [W-1:0] pk(input logic [FW-1:0] f, input logic ar, input logic bz,
                                        input logic ss, input logic dn, input logic er);
        return {f, ar, bz, ss, dn, er};
    endfunction

    function automatic logic [W-1:0] got();
        return {freq, accum_rst, busy, sweep_start, done, err};
    endfunction

    task automatic cfg(input logic [FW-1:0] fs, input logic [FW-1:0] fe, input logic [FW-1:0] st,
                       input int d, input int rp, input logic sp);
        f_start    = fs;
        f_stop     = fe;
        f_step     = st;
        dwell      = DW'(d);
        repeats    = RW'(rp);
        sync_phase = sp;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endtask

    // Expected cycles for nsw sweeps; step k holds fs + k*st for D cycles.
    task automatic push_run(input logic [FW-1:0] fs, input logic [FW-1:0] fe, input logic [FW-1:0] st,
                            input int d, input logic sp, input int nsw, input bit fin);
        int dd;
        dd = (d == 0) ? 1 : d;
        for (int s = 0; s < nsw; s++) begin
            longint unsigned f;
            longint unsigned nx;
            bit first;
            f = longint'(fs);
            first = 1'b1;
            while (1) begin
                for (int c = 0; c < dd; c++) begin
                    exp_q.push_back(pk(FW'(f), first && sp, 1'b1, first, 1'b0, 1'b0));
                    first = 1'b0;
                end
                nx = f + longint'(st);
                if (st != '0 && nx <= longint'(fe)) f = nx;
                else break;
            end
        end
        if (fin) exp_q.push_back(pk('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        rst = 1'b0;
        push_idle(4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b1;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL reset cyc=%0d got=%h exp=%h", i, got(), e);
        end
    endtask

    task automatic test_basic_sweep();
        logic [W-1:0] e;
        cfg(100, 400, 100, 3, 1, 1'b1);
        start = 1'b1;
        push_run(100, 400, 100, 3, 1'b1, 1, 1'b1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL basic cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
    endtask

    task automatic test_repeats();
        logic [W-1:0] e;
        cfg(100, 400, 100, 3, 3, 1'b1);
        start = 1'b1;
        push_run(100, 400, 100, 3, 1'b1, 3, 1'b1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL repeats cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e;
        cfg(28'hFFFFF00, 28'hFFFFFFF, 28'h80, 0, 1, 1'b0);
        start = 1'b1;
        exp_q.push_back(pk(28'hFFFFF00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(pk(28'hFFFFF80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL overflow cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
    endtask

    task automatic test_single_tone_err();
        logic [W-1:0] e;
        cfg(777, 1000, 0, 5, 2, 1'b1);
        start = 1'b1;
        push_run(777, 1000, 0, 5, 1'b1, 2, 1'b1);
        push_idle(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL tone cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
        cfg(500, 400, 10, 2, 1, 1'b1);
        start = 1'b1;
        exp_q.push_back(pk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL err_start cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
    endtask

    task automatic test_continuous_abort();
        logic [W-1:0] e;
        cfg(10, 30, 10, 2, 0, 1'b1);
        start = 1'b1;
        push_run(10, 30, 10, 2, 1'b1, 11, 1'b0);
        push_idle(3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL continuous cyc=%0d got=%h exp=%h", i + 1, got(), e);
            // Cycle 66 is the last dwell cycle of sweep 11, so this abort meets a sweep end.
            if (i == 65) abort = 1'b1;
        end
        cfg(20, 40, 10, 1, 1, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        push_idle(3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL start_abort cyc=%0d got=%h exp=%h", i + 1, got(), e);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        cfg(100, 400, 100, 3, 1, 1'b1);
        start = 1'b1;
        exp_q.push_back(pk(100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(pk(100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk(100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pk(200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        push_idle(4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i + 1, got(), e);
            if (i == 3) rst = 1'b0;
            if (i == 4) rst = 1'b1;
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] e;
        cfg(100, 400, 100, 3, 1, 1'b0);
        start = 1'b1;
        push_run(100, 400, 100, 3, 1'b0, 1, 1'b1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (got() === e) n_pass++;
            else $display("FAIL ignored_start cyc=%0d got=%h exp=%h", i + 1, got(), e);
            if (i == 4) begin
                cfg(50, 9999, 1, 1, 5, 1'b1);
                start = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg(0, 0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_basic_sweep();
        test_repeats();
        test_overflow();
        test_single_tone_err();
        test_continuous_abort();
        test_reset_mid();
        test_ignored_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
